fb_pixel_sink: RTL and testbench

Receiving end of the painter's pixel-write interface. It watches the painter's `paint_x_co`/`paint_y_co`/`color`/`print_enable` outputs and captures exactly one pixel per `print_enable` pulse into a small FIFO. It then drains the FIFO into the framebuffer RAM write port with address = y·SCR_WIDTH + x. It also provides a full-screen clear sweep, and sits between the painter and the VGA framebuffer memory.

---
 rtl/fb_pixel_sink_pkg.sv | 19 +
 rtl/fb_pixel_sink_fifo.sv | 54 +++++
 rtl/fb_pixel_sink.sv | 200 ++++++++++++++++++++
 tb/tb_fb_pixel_sink.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pixel_sink_pkg.sv
// Shared constants for the framebuffer pixel sink: default geometry, FSM state codes
// and a frame-size helper used by the sweep logic.
package fb_pixel_sink_pkg;

    localparam int DEF_SCR_WIDTH  = 160;
    localparam int DEF_SCR_HEIGHT = 120;
    localparam int DEF_COLOR_SIZE = 3;
    localparam int DEF_ADDR_BITS  = 15;
    localparam int DEF_FIFO_DEPTH = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    function automatic int frame_size(input int width, input int height);
        return width * height;
    endfunction

endpackage

// File: rtl/fb_pixel_sink_fifo.sv
// pixel_fifo: small synchronous FIFO with first-word-fall-through read, reset to empty.
module pixel_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] slot_reg [DEPTH];
    logic [PTR_W:0]   wr_ptr_reg;
    logic [PTR_W:0]   rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                   (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);

    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign dout = slot_reg[rd_ptr_reg[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            slot_reg[wr_ptr_reg[PTR_W-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_pixel_sink.sv
// fb_pixel_sink: captures one pixel per print_enable pulse and drains it into the
// framebuffer write port; also runs a full-screen clear sweep. Optional macro: OOB_CHECK_EN.
module fb_pixel_sink
    import fb_pixel_sink_pkg::*;
#(
    parameter int SCR_WIDTH  = DEF_SCR_WIDTH,
    parameter int SCR_HEIGHT = DEF_SCR_HEIGHT,
    parameter int COLOR_SIZE = DEF_COLOR_SIZE,
    parameter int ADDR_BITS  = DEF_ADDR_BITS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                           Clck,
    input  logic                           Reset,
    input  logic [$clog2(SCR_WIDTH)-1:0]   paint_x_co,
    input  logic [$clog2(SCR_HEIGHT)-1:0]  paint_y_co,
    input  logic [COLOR_SIZE-1:0]          color,
    input  logic                           print_enable,
    input  logic                           clear_req,
    input  logic [COLOR_SIZE-1:0]          clear_color,
    output logic [ADDR_BITS-1:0]           mem_addr,
    output logic [COLOR_SIZE-1:0]          mem_data,
    output logic                           mem_we,
    input  logic                           mem_ready,
    output logic                           busy,
    output logic                           overflow,
    output logic                           oob_drop
);

    localparam int X_BITS       = $clog2(SCR_WIDTH);
    localparam int Y_BITS       = $clog2(SCR_HEIGHT);
    localparam int ENTRY_W      = X_BITS + Y_BITS + COLOR_SIZE;
    localparam int FRAME_PIXELS = frame_size(SCR_WIDTH, SCR_HEIGHT);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(FRAME_PIXELS - 1);

    logic [1:0]            state_reg;
    logic                  pe_reg;
    logic                  clear_pend_reg;
    logic [COLOR_SIZE-1:0] clear_color_reg;
    logic [ADDR_BITS-1:0]  mem_addr_reg;
    logic [COLOR_SIZE-1:0] mem_data_reg;
    logic                  mem_we_reg;
    logic                  overflow_reg;

    logic                  capture;
    logic                  in_bounds;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  drop;
    logic [ENTRY_W-1:0]    fifo_din;
    logic [ENTRY_W-1:0]    fifo_dout;
    logic [X_BITS-1:0]     head_x;
    logic [Y_BITS-1:0]     head_y;
    logic [COLOR_SIZE-1:0] head_color;
    logic [ADDR_BITS-1:0]  head_addr;
    logic                  accept;
    logic                  clear_take;
    logic                  start_clear;

    // Rising edge of the strobe: a pulse of any length captures once.
    assign capture = print_enable && !pe_reg;

`ifdef OOB_CHECK_EN
    logic oob_drop_reg;

    assign in_bounds = (32'(paint_x_co) < 32'(SCR_WIDTH)) && (32'(paint_y_co) < 32'(SCR_HEIGHT));
    assign oob_drop  = oob_drop_reg;

    always_ff @(posedge Clck) begin
        if (Reset) begin
            oob_drop_reg <= 1'b0;
        end else if (capture && !in_bounds) begin
            oob_drop_reg <= 1'b1;
        end
    end
`else
    assign in_bounds = 1'b1;
    assign oob_drop  = 1'b0;
`endif

    assign fifo_din  = {paint_x_co, paint_y_co, color};
    assign fifo_push = capture && in_bounds && (!fifo_full || fifo_pop);
    assign drop      = capture && in_bounds && fifo_full && !fifo_pop;

    pixel_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (Clck),
        .srst  (Reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_x     = fifo_dout[ENTRY_W-1 -: X_BITS];
    assign head_y     = fifo_dout[COLOR_SIZE +: Y_BITS];
    assign head_color = fifo_dout[COLOR_SIZE-1:0];
    assign head_addr  = ADDR_BITS'(head_y) * ADDR_BITS'(SCR_WIDTH) + ADDR_BITS'(head_x);

    assign accept = mem_we_reg && mem_ready;

    // A clear_req seen directly in IDLE/WRITE starts the sweep without waiting for the latch.
    assign clear_take = clear_pend_reg || (clear_req && (state_reg != ST_CLEAR));

    always_comb begin
        fifo_pop    = 1'b0;
        start_clear = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (clear_take) begin
                    start_clear = 1'b1;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                end
            end
            ST_WRITE: begin
                if (accept) begin
                    if (clear_take) begin
                        start_clear = 1'b1;
                    end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge Clck) begin
        if (Reset) begin
            state_reg       <= ST_IDLE;
            pe_reg          <= 1'b0;
            clear_pend_reg  <= 1'b0;
            clear_color_reg <= '0;
            mem_addr_reg    <= '0;
            mem_data_reg    <= '0;
            mem_we_reg      <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            pe_reg <= print_enable;

            if (drop) begin
                overflow_reg <= 1'b1;
            end

            if (start_clear) begin
                clear_pend_reg <= 1'b0;
            end else if (clear_req && !clear_pend_reg && (state_reg != ST_CLEAR)) begin
                clear_pend_reg  <= 1'b1;
                clear_color_reg <= clear_color;
            end

            case (state_reg)
                ST_IDLE, ST_WRITE: begin
                    if (start_clear) begin
                        state_reg    <= ST_CLEAR;
                        mem_addr_reg <= '0;
                        mem_data_reg <= clear_pend_reg ? clear_color_reg : clear_color;
                        mem_we_reg   <= 1'b1;
                    end else if (fifo_pop) begin
                        state_reg    <= ST_WRITE;
                        mem_addr_reg <= head_addr;
                        mem_data_reg <= head_color;
                        mem_we_reg   <= 1'b1;
                    end else if ((state_reg == ST_WRITE) && accept) begin
                        state_reg  <= ST_IDLE;
                        mem_we_reg <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (accept) begin
                        if (mem_addr_reg == LAST_ADDR) begin
                            state_reg  <= ST_IDLE;
                            mem_we_reg <= 1'b0;
                        end else begin
                            mem_addr_reg <= mem_addr_reg + ADDR_BITS'(1);
                        end
                    end
                end
                default: begin
                    state_reg  <= ST_IDLE;
                    mem_we_reg <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr = mem_addr_reg;
    assign mem_data = mem_data_reg;
    assign mem_we   = mem_we_reg;
    assign overflow = overflow_reg;
    assign busy     = !fifo_empty || mem_we_reg || clear_pend_reg || (state_reg == ST_CLEAR);

endmodule

// File: tb/tb_fb_pixel_sink.sv
// Directed testbench for fb_pixel_sink; honours OOB_CHECK_EN for the out-of-bounds scenario.
module tb_fb_pixel_sink;

    logic        Clck = 1'b0;
    logic        Reset = 1'b1;
    logic [7:0]  paint_x_co = '0;
    logic [6:0]  paint_y_co = '0;
    logic [2:0]  color = '0;
    logic        print_enable = 1'b0;
    logic        clear_req = 1'b0;
    logic [2:0]  clear_color = '0;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_we;
    logic        mem_ready = 1'b0;
    logic        busy;
    logic        overflow;
    logic        oob_drop;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];

    fb_pixel_sink dut (
        .Clck         (Clck),
        .Reset        (Reset),
        .paint_x_co   (paint_x_co),
        .paint_y_co   (paint_y_co),
        .color        (color),
        .print_enable (print_enable),
        .clear_req    (clear_req),
        .clear_color  (clear_color),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_we       (mem_we),
        .mem_ready    (mem_ready),
        .busy         (busy),
        .overflow     (overflow),
        .oob_drop     (oob_drop)
    );

    always #5 Clck = ~Clck;

    always @(posedge Clck) cyc <= cyc + 1;

    always @(negedge Clck) begin
        if (!Reset && mem_we && mem_ready) begin
            wr_addr.push_back(int'(mem_addr));
            wr_data.push_back(int'(mem_data));
            wr_cyc.push_back(cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clck);
            #1;
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    task automatic wait_not_busy(input int budget, output bit timed_out);
        int k = 0;
        while (busy && k < budget) begin
            step(1);
            k++;
        end
        timed_out = busy;
    endtask

    task automatic wait_addr(input int addr, input int budget, output bit timed_out);
        int k = 0;
        while (int'(mem_addr) != addr && k < budget) begin
            step(1);
            k++;
        end
        timed_out = (int'(mem_addr) != addr);
    endtask

    task automatic pulse(input int x, input int y, input int c, input int len);
        paint_x_co = 8'(x);
        paint_y_co = 7'(y);
        color = 3'(c);
        print_enable = 1'b1;
        step(len);
        print_enable = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step(3);
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we actual=%0b required=0", mem_we); end
        checks++; if (mem_addr !== 15'd0) begin failures++; $display("FAIL reset_mem_addr actual=%0d required=0", mem_addr); end
        checks++; if (mem_data !== 3'd0) begin failures++; $display("FAIL reset_mem_data actual=%0d required=0", mem_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%0b required=0", busy); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow actual=%0b required=0", overflow); end
        checks++; if (oob_drop !== 1'b0) begin failures++; $display("FAIL reset_oob_drop actual=%0b required=0", oob_drop); end
        Reset = 1'b0;
        step(1);
        $display("test_reset: outputs checked after reset");
    endtask

    task automatic test_single();
        int n;
        int got;
        mem_ready = 1'b1;
        clear_log();
        n = cyc;
        pulse(5, 3, 6, 3);
        step(6);
        checks++; if (wr_addr.size() != 1) begin failures++; $display("FAIL single_count actual=%0d required=1", wr_addr.size()); end
        got = (wr_addr.size() > 0) ? wr_addr[0] : -1;
        checks++; if (got != 485) begin failures++; $display("FAIL single_addr actual=%0d required=485", got); end
        got = (wr_data.size() > 0) ? wr_data[0] : -1;
        checks++; if (got != 6) begin failures++; $display("FAIL single_data actual=%0d required=6", got); end
        got = (wr_cyc.size() > 0) ? wr_cyc[0] : -1;
        checks++; if (got != n + 2) begin failures++; $display("FAIL single_latency actual=%0d required=%0d", got, n + 2); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy actual=%0b required=0", busy); end
        $display("test_single: pixel (5,3) color 6 -> %0d writes", wr_addr.size());
    endtask

    task automatic test_overflow();
        int r;
        int got;
        bit to;
        mem_ready = 1'b0;
        clear_log();
        for (int i = 0; i < 6; i++) begin
            pulse(10 + i, i, i + 1, 2);
            step(4);
        end
        step(2);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag actual=%0b required=1", overflow); end
        checks++; if (wr_addr.size() != 0) begin failures++; $display("FAIL ovf_no_write actual=%0d required=0", wr_addr.size()); end
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL ovf_hold_we actual=%0b required=1", mem_we); end
        checks++; if (mem_addr !== 15'd10) begin failures++; $display("FAIL ovf_hold_addr actual=%0d required=10", mem_addr); end
        mem_ready = 1'b1;
        r = cyc;
        wait_not_busy(50, to);
        checks++; if (to) begin failures++; $display("FAIL ovf_drain_timeout actual=busy required=idle"); end
        checks++; if (wr_addr.size() != 5) begin failures++; $display("FAIL ovf_count actual=%0d required=5", wr_addr.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (wr_addr.size() > i) ? wr_addr[i] : -1;
            checks++; if (got != i * 160 + 10 + i) begin failures++; $display("FAIL ovf_addr%0d actual=%0d required=%0d", i, got, i * 160 + 10 + i); end
            got = (wr_data.size() > i) ? wr_data[i] : -1;
            checks++; if (got != i + 1) begin failures++; $display("FAIL ovf_data%0d actual=%0d required=%0d", i, got, i + 1); end
            got = (wr_cyc.size() > i) ? wr_cyc[i] : -1;
            checks++; if (got != r + i) begin failures++; $display("FAIL back_to_back%0d actual=%0d required=%0d", i, got, r + i); end
        end
        step(5);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky actual=%0b required=1", overflow); end
        $display("test_overflow: 6 pulses stalled -> %0d writes, overflow=%0b", wr_addr.size(), overflow);
    endtask

    task automatic test_clear();
        int c;
        int bad;
        int idle_cyc;
        int last;
        bit to;
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
        mem_ready = 1'b1;
        clear_color = 3'b000;
        clear_log();
        clear_req = 1'b1;
        c = cyc;
        step(1);
        clear_req = 1'b0;
        clear_color = 3'b111;
        wait_not_busy(20000, to);
        idle_cyc = cyc;
        checks++; if (to) begin failures++; $display("FAIL clear_timeout actual=busy required=idle"); end
        checks++; if (wr_addr.size() != 19200) begin failures++; $display("FAIL clear_count actual=%0d required=19200", wr_addr.size()); end
        bad = 0;
        for (int i = 0; i < wr_addr.size(); i++) begin
            if (wr_addr[i] != i || wr_data[i] != 0 || wr_cyc[i] != c + 1 + i) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL clear_sequence actual=%0d_bad_writes required=0", bad); end
        last = (wr_cyc.size() > 0) ? wr_cyc[wr_cyc.size() - 1] : -1;
        checks++; if (idle_cyc != last + 1) begin failures++; $display("FAIL clear_busy_fall actual=%0d required=%0d", idle_cyc, last + 1); end
        $display("test_clear: sweep of %0d writes, busy low at cycle %0d", wr_addr.size(), idle_cyc);
    endtask

    task automatic test_clear_pixel();
        int got;
        bit to;
        clear_log();
        clear_color = 3'b101;
        clear_req = 1'b1;
        step(1);
        clear_req = 1'b0;
        clear_color = 3'b000;
        wait_addr(500, 2000, to);
        checks++; if (to) begin failures++; $display("FAIL clpix_reach500 actual=%0d required=500", mem_addr); end
        pulse(1, 1, 2, 2);
        wait_not_busy(20000, to);
        checks++; if (to) begin failures++; $display("FAIL clpix_timeout actual=busy required=idle"); end
        checks++; if (wr_addr.size() != 19201) begin failures++; $display("FAIL clpix_count actual=%0d required=19201", wr_addr.size()); end
        got = (wr_addr.size() > 19199) ? wr_addr[19199] : -1;
        checks++; if (got != 19199) begin failures++; $display("FAIL clpix_last_sweep actual=%0d required=19199", got); end
        got = (wr_data.size() > 19199) ? wr_data[19199] : -1;
        checks++; if (got != 5) begin failures++; $display("FAIL clpix_sweep_color actual=%0d required=5", got); end
        got = (wr_addr.size() > 19200) ? wr_addr[19200] : -1;
        checks++; if (got != 161) begin failures++; $display("FAIL clpix_pixel_addr actual=%0d required=161", got); end
        got = (wr_data.size() > 19200) ? wr_data[19200] : -1;
        checks++; if (got != 2) begin failures++; $display("FAIL clpix_pixel_data actual=%0d required=2", got); end
        $display("test_clear_pixel: %0d writes, pixel after sweep", wr_addr.size());
    endtask

    task automatic test_oob();
        int got;
        clear_log();
        pulse(160, 0, 3, 2);
        step(6);
`ifdef OOB_CHECK_EN
        checks++; if (wr_addr.size() != 0) begin failures++; $display("FAIL oob_count actual=%0d required=0", wr_addr.size()); end
        checks++; if (oob_drop !== 1'b1) begin failures++; $display("FAIL oob_flag actual=%0b required=1", oob_drop); end
`else
        checks++; if (wr_addr.size() != 1) begin failures++; $display("FAIL oob_count actual=%0d required=1", wr_addr.size()); end
        got = (wr_addr.size() > 0) ? wr_addr[0] : -1;
        checks++; if (got != 160) begin failures++; $display("FAIL oob_addr actual=%0d required=160", got); end
        checks++; if (oob_drop !== 1'b0) begin failures++; $display("FAIL oob_flag actual=%0b required=0", oob_drop); end
`endif
        got = (wr_addr.size() > 0) ? wr_addr[0] : -1;
        $display("test_oob: x=160 y=0 -> %0d writes, oob_drop=%0b", wr_addr.size(), oob_drop);
    endtask

    task automatic test_reset_mid_clear();
        bit to;
        clear_log();
        clear_req = 1'b1;
        step(1);
        clear_req = 1'b0;
        wait_addr(1000, 3000, to);
        checks++; if (to) begin failures++; $display("FAIL rst_reach1000 actual=%0d required=1000", mem_addr); end
        Reset = 1'b1;
        step(1);
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we actual=%0b required=0", mem_we); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy actual=%0b required=0", busy); end
        checks++; if (mem_addr !== 15'd0) begin failures++; $display("FAIL rst_mem_addr actual=%0d required=0", mem_addr); end
        Reset = 1'b0;
        clear_log();
        step(50);
        checks++; if (wr_addr.size() != 0) begin failures++; $display("FAIL rst_no_resume actual=%0d required=0", wr_addr.size()); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_idle_busy actual=%0b required=0", busy); end
        $display("test_reset_mid_clear: %0d writes after reset", wr_addr.size());
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_clear();
        test_clear_pixel();
        test_oob();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
